// File: rtl/reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined reduction tree.
// Provides the operator enum, tree sizing functions and the padding identity.
package reduce_pkg;

  typedef enum logic [1:0] {
    REDUCE_OR,
    REDUCE_AND,
    REDUCE_XOR
  } reduce_op_t;

  // base**exp for elaboration-time sizing
  function automatic int unsigned reduce_pow(input int unsigned base, input int unsigned exp);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < exp; i++) p = p * base;
    return p;
  endfunction

  // ceil(log_radix(width)), never below 1; a degenerate radix returns 1 so the
  // elaboration error, not an endless loop, reports the problem
  function automatic int unsigned reduce_levels(input int unsigned width, input int unsigned radix);
    int unsigned lv;
    int unsigned cap;
    lv  = 1;
    cap = radix;
    if (radix < 2) return 1;
    while (cap < width) begin
      cap = cap * radix;
      lv  = lv + 1;
    end
    return lv;
  endfunction

  // Bit offset of tree level m inside the flattened level bus: sum of radix**i, i<m
  function automatic int unsigned reduce_offset(input int unsigned radix, input int unsigned m);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < m; i++) off = off + reduce_pow(radix, i);
    return off;
  endfunction

  // Identity element of the operator, used to pad the input to a full tree
  function automatic logic reduce_identity(input reduce_op_t op);
    return (op == REDUCE_AND);
  endfunction

endpackage

// File: rtl/reduce_tree_stage.sv
// One registered tree level: reduces each RADIX-bit group of vals_i with OP and
// registers the result together with the valid bit and tag.
// Ports: clk, reset_n (async, active low), flush_i (sync valid clear),
//        load_i (downstream ready for this stage), valid_i/vals_i/tag_i from the
//        previous level, valid_o/vals_o/tag_o registered towards the next level.
module reduce_tree_stage
  import reduce_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned RADIX = 4,
  parameter reduce_op_t  OP    = REDUCE_OR,
  parameter int unsigned TAG_W = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    load_i,
  input  logic                    valid_i,
  input  logic [IN_W-1:0]         vals_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    valid_o,
  output logic [IN_W/RADIX-1:0]   vals_o,
  output logic [TAG_W-1:0]        tag_o
);

  localparam int unsigned OUT_W = IN_W / RADIX;

  logic             valid_q, valid_d;
  logic [OUT_W-1:0] node_c;
  logic [OUT_W-1:0] vals_q, vals_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // One tree node per output bit
  for (genvar j = 0; j < OUT_W; j++) begin : g_node
    logic [RADIX-1:0] grp;
    assign grp = vals_i[j*RADIX +: RADIX];
    if (OP == REDUCE_AND) begin : g_and
      assign node_c[j] = &grp;
    end else if (OP == REDUCE_XOR) begin : g_xor
      assign node_c[j] = ^grp;
    end else begin : g_or
      assign node_c[j] = |grp;
    end
  end

  // Next state: flush beats a simultaneous load; data loads whenever the stage
  // may advance, regardless of valid
  always_comb begin : p_next
    valid_d = valid_q;
    vals_d  = vals_q;
    tag_d   = tag_q;
    if (load_i) begin
      valid_d = valid_i;
      vals_d  = node_c;
      tag_d   = tag_i;
    end
    if (flush_i) valid_d = 1'b0;
  end

  // Valid bit: the only state that needs reset
  always_ff @(posedge clk or negedge reset_n) begin : p_valid
    if (!reset_n) valid_q <= 1'b0;
    else          valid_q <= valid_d;
  end

  // Payload registers
  always_ff @(posedge clk) begin : p_data
    vals_q <= vals_d;
    tag_q  <= tag_d;
  end

  assign valid_o = valid_q;
  assign vals_o  = vals_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-input bitwise reduction (OR/AND/XOR), one register per tree
// level, tag carried alongside, valid/ready at both ends, synchronous flush.
// Ports: clk, reset_n (async, active low), flush,
//        in_valid/in_ready/in_vals/in_tag   operand side,
//        out_valid/out_ready/out_val/out_tag result side,
//        busy  any stage holds a valid operand.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned RADIX = 4,
  parameter reduce_op_t  OP    = REDUCE_OR,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vals,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_val,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned LEVELS  = reduce_levels(WIDTH, RADIX);
  localparam int unsigned PAD_W   = reduce_pow(RADIX, LEVELS);
  localparam int unsigned PAD_OFF = reduce_offset(RADIX, LEVELS);
  localparam int unsigned TOT_W   = reduce_offset(RADIX, LEVELS + 1);
  localparam logic        IDENT   = reduce_identity(OP);

  if (WIDTH < 2) begin : g_err_width
    $error("reduce_tree_pipe: WIDTH must be >= 2");
  end
  if (RADIX < 2 || RADIX > 8) begin : g_err_radix
    $error("reduce_tree_pipe: RADIX must be in 2..8");
  end

  // Level m (width RADIX**m) lives at reduce_offset(RADIX, m); level LEVELS is
  // the padded input, level 0 the single result bit
  logic [TOT_W-1:0]  lvl_bus;
  logic [LEVELS:0]   valid_s;
  logic [TAG_W-1:0]  tag_s [LEVELS+1];
  logic [LEVELS-1:0] ready_c;

  if (PAD_W > WIDTH) begin : g_pad
    assign lvl_bus[PAD_OFF +: PAD_W] = {{(PAD_W - WIDTH){IDENT}}, in_vals};
  end else begin : g_nopad
    assign lvl_bus[PAD_OFF +: PAD_W] = in_vals;
  end

  assign valid_s[0] = in_valid;
  assign tag_s[0]   = in_tag;

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int unsigned IN_W    = reduce_pow(RADIX, LEVELS - k);
    localparam int unsigned IN_OFF  = reduce_offset(RADIX, LEVELS - k);
    localparam int unsigned OUT_OFF = reduce_offset(RADIX, LEVELS - k - 1);

    // Unrolled ready chain: stage k may advance unless it and every stage
    // downstream of it are full while the consumer stalls
    assign ready_c[k] = out_ready | ~(&valid_s[LEVELS:k+1]);

    reduce_tree_stage #(
      .IN_W  (IN_W),
      .RADIX (RADIX),
      .OP    (OP),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush),
      .load_i  (ready_c[k]),
      .valid_i (valid_s[k]),
      .vals_i  (lvl_bus[IN_OFF +: IN_W]),
      .tag_i   (tag_s[k]),
      .valid_o (valid_s[k+1]),
      .vals_o  (lvl_bus[OUT_OFF +: IN_W/RADIX]),
      .tag_o   (tag_s[k+1])
    );
  end

  assign in_ready  = ready_c[0];
  assign out_valid = valid_s[LEVELS];
  assign out_val   = lvl_bus[0];
  assign out_tag   = tag_s[LEVELS];
  assign busy      = |valid_s[LEVELS:1];

endmodule

// File: doc/reduce_tree_pipe.md
Name: reduce_tree_pipe

Overview:
- Parametrised, pipelined N-input bitwise reduction tree (OR / AND / XOR), one register stage per tree level.
- Successor to the fixed 16-input radix-4 OR gate.
- Used in the out-of-order core for wide "any-ready", "all-committed" and parity checks over ROB/RS bit vectors, where a single-cycle wide OR breaks timing.
- Carries a tag (e.g. ROB index) alongside each reduction.
- Valid/ready elastic handshake at both ends; synchronous flush.

Parameters:
- WIDTH, 64, number of input bits to reduce (>= 2).
- RADIX, 4, fan-in per tree node (2..8).
- OP, REDUCE_OR, reduction operator, type reduce_op_t: REDUCE_OR, REDUCE_AND, REDUCE_XOR.
- TAG_W, 6, width of the sideband tag carried with each operand.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops every in-flight operand.
- in_valid  in  1  input operand valid.
- in_ready  out  1  stage 0 can accept this cycle.
- in_vals  in  WIDTH  bit vector to reduce.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_val  out  1  reduction result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any stage holds a valid operand.

Behaviour:
- LEVELS = ceil(log_RADIX(WIDTH)), minimum 1.
  - WIDTH=64, RADIX=4 -> 3.
  - WIDTH=16, RADIX=4 -> 2.
  - WIDTH=5, RADIX=4 -> 2.
- Padding: the input is padded to RADIX**LEVELS bits with the operator identity (OR/XOR: 0, AND: 1). Padding never affects the result.
- Stage k (0..LEVELS-1):
  - Registers a valid bit, the tag, and the partial vector of width RADIX**(LEVELS-1-k).
  - Each partial bit is OP over RADIX bits of the previous level.
  - Final stage width is 1, driving out_val.
- Latency: operand accepted on edge t (in_valid & in_ready) is presented at out_valid on edge t+LEVELS-1, i.e. visible LEVELS cycles after presentation when no stalls occur.
- Throughput: 1 operand/cycle when out_ready is held high.
- Per-stage ready:
  - ready_k = !valid_k | ready_{k+1}.
  - ready_LEVELS = out_ready.
  - in_ready = ready_0.
  - The ready chain is combinational, so bubbles collapse: a stalled output does not block upstream stages that hold bubbles.
- Stage update: stage k loads from stage k-1 (or the input) when ready_k. The loaded valid is valid_{k-1} (or in_valid). Otherwise it holds.
- Data and tag registers may load regardless of valid (no reset needed). Valid bits always reset.
- out_valid = valid_{LEVELS-1}. out_val and out_tag are stable while out_valid & !out_ready.
- busy = OR of all valid bits.
- Flush:
  - All valid bits clear on the next edge.
  - An input presented in the same cycle is dropped: in_ready still reads ready_0, but no load takes effect.
  - Flush overrides any simultaneous accept.
- Reset (reset_n low, any time including mid-stream):
  - All valid bits cleared immediately.
  - out_valid=0, busy=0, in_ready=1.
  - out_val and out_tag are don't-care; the bench must not check them while out_valid=0.
- Elaboration errors: WIDTH<2, RADIX<2, RADIX>8.

Decomposition:
- Package reduce_pkg holds:
  - typedef enum reduce_op_t {REDUCE_OR, REDUCE_AND, REDUCE_XOR}.
  - function reduce_levels(width, radix).
  - function reduce_identity(op).
- Sub-module reduce_tree_stage:
  - Parameters IN_W, RADIX, OP, TAG_W.
  - Holds one registered level with valid/ready.
  - Instantiated LEVELS times via generate.
- Top level computes padding and chains the stages.

Test Plan:
1. Reset, then WIDTH=64 OR; in_vals=0 with tag 5, then in_vals=64'h0000_0100_0000_0000 with tag 6, out_ready=1 -> out_val=0/tag 5, then 1/tag 6, on consecutive cycles, first at 3 cycles after acceptance.
2. OP=AND, WIDTH=5 (padding): in_vals=5'b11111 -> 1; in_vals=5'b11110 -> 0; latency 2.
3. OP=XOR, WIDTH=16; stream all 65536 values back-to-back with tag=i[5:0] -> out_val = parity(i), tags in order, one result per cycle.
4. Back-pressure: hold out_ready=0 after 3 accepts -> in_ready drops only after all 3 stages fill. Then release -> the 3 results drain in order, none lost or duplicated.
5. Bubble collapse: send one operand, gap 2 cycles, send another, out_ready=0 -> both reach stages 2 and 1 with no loss; in_ready stays 1 until stage 0 also fills.
6. Flush with 2 in flight plus a simultaneous in_valid -> next cycle busy=0 and out_valid=0; no stale results appear afterward. Repeat with reset_n pulsed low mid-stream -> out_valid falls asynchronously.
